// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the instruction-fetch next-address controller.
// Holds the FSM encoding, the instruction stride and the window clamp.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } pc_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Word-align first, then wrap anything beyond the program window to 0.
  function automatic logic [63:0] clamp_addr(input logic [63:0] addr,
                                             input logic [63:0] last);
    logic [63:0] aligned;
    aligned = addr & ~64'd3;
    return (aligned > last) ? 64'd0 : aligned;
  endfunction

endpackage

// File: rtl/pc_sequencer_stall_watchdog.sv
// Saturating count of consecutive accepted stalls with a sticky timeout flag.
// The flag sets on the edge that ends the (MAX_STALL+1)-th consecutive stall.
module stall_watchdog #(
  parameter int MAX_STALL = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_stall_accept,
  output logic o_stall_timeout
);

  localparam int CW = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_STALL + 1);

  logic [CW-1:0] r_count;
  logic          r_timeout;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_stall_accept) begin
        r_count <= '0;
      end else if (r_count != LIMIT) begin
        r_count <= r_count + 1'b1;
      end
      if (i_stall_accept && (r_count >= LIMIT - 1'b1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_stall_timeout = r_timeout;

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller: picks jump/branch/hold/increment for the PC register,
// enforces the post-reset settle cycle and program-window wrap, reports status.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PROG_LAST = 24,
  parameter int MAX_STALL = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] PC,
  input  logic             Stall,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] NextAddress,
  output logic             IF_Flush,
  output logic             AddrFault,
  output logic             StallTimeout,
  output logic [1:0]       State
);

  pc_state_t        r_state;
  pc_state_t        w_next_state;
  logic             r_addr_fault;
  logic             w_active;
  logic             w_redirect;
  logic             w_stall_accept;
  logic             w_target_oow;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_clamped;

  // A redirect wins over a simultaneous stall, so the stall is not accepted.
  assign w_active       = (r_state != HOLD);
  assign w_redirect     = w_active & (Jump | Branch);
  assign w_stall_accept = w_active & Stall & ~Jump & ~Branch;
  assign w_target       = Jump ? JumpTarget : BranchTarget;
  assign w_target_oow   = (64'(w_target) > 64'(PROG_LAST));
  assign w_pc_inc       = PC + WIDTH'(INSTR_BYTES);

  always_comb begin
    w_sel = w_pc_inc;
    if (Jump) begin
      w_sel = JumpTarget;
    end else if (Branch) begin
      w_sel = BranchTarget;
    end else if (Stall) begin
      w_sel = PC;
    end
  end

  assign w_clamped   = WIDTH'(clamp_addr(64'(w_sel), 64'(PROG_LAST)));
  assign NextAddress = w_active ? w_clamped : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HOLD:    w_next_state = RUN;
      default: begin
        if (Jump || Branch) begin
          w_next_state = FLUSH;
        end else if (Stall) begin
          w_next_state = STALL;
        end else begin
          w_next_state = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= HOLD;
      r_addr_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_redirect && w_target_oow) begin
        r_addr_fault <= 1'b1;
      end
    end
  end

  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_stall_watchdog (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_stall_accept (w_stall_accept),
    .o_stall_timeout(StallTimeout)
  );

  // IF_Flush is a decode of the registered state, so it is high exactly in FLUSH.
  assign IF_Flush  = (r_state == FLUSH);
  assign AddrFault = r_addr_fault;
  assign State     = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table plus hand-written
// sequences for async reset during FLUSH and the stall watchdog threshold.
module tb_pc_sequencer;

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;
  localparam int NVEC = 20;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] NextAddress;
  logic        IF_Flush;
  logic        AddrFault;
  logic        StallTimeout;
  logic [1:0]  State;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] exp_next;
    logic [1:0]  exp_state;
    logic        exp_flush;
    logic        exp_fault;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[NVEC];

  pc_sequencer #(
    .WIDTH    (32),
    .PROG_LAST(24),
    .MAX_STALL(15)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC          (PC),
    .Stall       (Stall),
    .Branch      (Branch),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .NextAddress (NextAddress),
    .IF_Flush    (IF_Flush),
    .AddrFault   (AddrFault),
    .StallTimeout(StallTimeout),
    .State       (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic stall, input logic br,
                              input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                              input logic [31:0] en, input logic [1:0] es,
                              input logic ef, input logic ea, input logic et);
    vec_t v;
    v.pc = pc; v.stall = stall; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.exp_next = en; v.exp_state = es; v.exp_flush = ef; v.exp_fault = ea; v.exp_tmo = et;
    return v;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic stall, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    PC = pc; Stall = stall; Branch = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
  endtask

  task automatic check_all(input string tag, input logic [31:0] en, input logic [1:0] es,
                           input logic ef, input logic ea, input logic et);
    check({tag, " next"},  NextAddress, en);
    check({tag, " state"}, 32'(State), 32'(es));
    check({tag, " flush"}, 32'(IF_Flush), 32'(ef));
    check({tag, " fault"}, 32'(AddrFault), 32'(ea));
    check({tag, " tmo"},   32'(StallTimeout), 32'(et));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    //          pc            st br bt           jp jt     next          state    fl fa to
    vecs[0]  = mk(32'd0,        0, 0, 32'd0,     0, 32'd0, 32'd0,  S_HOLD,  0, 0, 0);
    vecs[1]  = mk(32'd0,        0, 0, 32'd0,     0, 32'd0, 32'd4,  S_RUN,   0, 0, 0);
    vecs[2]  = mk(32'd4,        0, 0, 32'd0,     0, 32'd0, 32'd8,  S_RUN,   0, 0, 0);
    vecs[3]  = mk(32'd8,        0, 0, 32'd0,     0, 32'd0, 32'd12, S_RUN,   0, 0, 0);
    vecs[4]  = mk(32'd12,       0, 0, 32'd0,     0, 32'd0, 32'd16, S_RUN,   0, 0, 0);
    vecs[5]  = mk(32'd16,       0, 0, 32'd0,     0, 32'd0, 32'd20, S_RUN,   0, 0, 0);
    vecs[6]  = mk(32'd20,       0, 0, 32'd0,     0, 32'd0, 32'd24, S_RUN,   0, 0, 0);
    vecs[7]  = mk(32'd24,       0, 0, 32'd0,     0, 32'd0, 32'd0,  S_RUN,   0, 0, 0);
    vecs[8]  = mk(32'd8,        1, 1, 32'd20,    0, 32'd0, 32'd20, S_RUN,   0, 0, 0);
    vecs[9]  = mk(32'd20,       0, 0, 32'd0,     0, 32'd0, 32'd24, S_FLUSH, 1, 0, 0);
    vecs[10] = mk(32'd24,       0, 0, 32'd0,     0, 32'd0, 32'd0,  S_RUN,   0, 0, 0);
    vecs[11] = mk(32'd0,        0, 1, 32'd16,    1, 32'd4, 32'd4,  S_RUN,   0, 0, 0);
    vecs[12] = mk(32'd4,        0, 1, 32'h30,    0, 32'd0, 32'd0,  S_FLUSH, 1, 0, 0);
    vecs[13] = mk(32'd0,        0, 0, 32'd0,     1, 32'd7, 32'd4,  S_FLUSH, 1, 1, 0);
    vecs[14] = mk(32'd4,        0, 0, 32'd0,     0, 32'd0, 32'd8,  S_FLUSH, 1, 1, 0);
    vecs[15] = mk(32'd8,        1, 0, 32'd0,     0, 32'd0, 32'd8,  S_RUN,   0, 1, 0);
    vecs[16] = mk(32'd8,        0, 0, 32'd0,     0, 32'd0, 32'd12, S_STALL, 0, 1, 0);
    vecs[17] = mk(32'd12,       0, 0, 32'd0,     0, 32'd0, 32'd16, S_RUN,   0, 1, 0);
    vecs[18] = mk(32'hFFFFFFFC, 0, 0, 32'd0,     0, 32'd0, 32'd0,  S_RUN,   0, 1, 0);
    vecs[19] = mk(32'h20,       0, 0, 32'd0,     0, 32'd0, 32'd0,  S_RUN,   0, 1, 0);

    // Reset held for two cycles; outputs must already be at reset values.
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    #1;
    check_all("in_reset", 32'd0, S_HOLD, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pc, vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].exp_next, vecs[i].exp_state,
                vecs[i].exp_flush, vecs[i].exp_fault, vecs[i].exp_tmo);
      @(negedge Clk);
    end

    // Async reset between edges while in FLUSH.
    drive(32'd4, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40);
    @(negedge Clk);
    drive(32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check_all("pre_areset", 32'd4, S_FLUSH, 1'b1, 1'b1, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check_all("areset", 32'd0, S_HOLD, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check_all("post_areset_hold", 32'd0, S_HOLD, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);

    // 15 consecutive stalls must not trip the watchdog.
    for (int i = 0; i < 15; i++) begin
      drive(32'd12, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      #1;
      check_all($sformatf("st15_%0d", i), 32'd12, (i == 0) ? S_RUN : S_STALL, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
    end
    drive(32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check_all("after15", 32'd16, S_STALL, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);

    // 16 consecutive stalls trip it on the 16th edge.
    for (int i = 0; i < 16; i++) begin
      drive(32'd12, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      #1;
      check_all($sformatf("st16_%0d", i), 32'd12, (i == 0) ? S_RUN : S_STALL, 1'b0, 1'b0, 1'b0);
      @(negedge Clk);
    end
    drive(32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check_all("after16", 32'd16, S_STALL, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    drive(32'd16, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check_all("tmo_sticky", 32'd20, S_RUN, 1'b0, 1'b0, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    check_all("tmo_reset", 32'd0, S_HOLD, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the instruction-fetch stage. Each cycle it computes the value presented to the program counter register's `Address` input: sequential increment, branch/jump redirect, or hold for a pipeline stall. It also enforces the post-reset settle cycle and the program-window wrap, and reports flush and fault status to the hazard unit. It sits between the hazard/branch logic and the PC register; the PC register's output feeds back as `PC`.

## Interface

**Parameters**

- `WIDTH`, 32: address width.
- `PROG_LAST`, 24: highest valid instruction byte address. Any address above it wraps to 0.
- `MAX_STALL`, 15: consecutive stall cycles tolerated before the timeout flag sets.

**Ports**

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PC`  in  WIDTH  current PC register value.
- `Stall`  in  1  hold fetch this cycle (load-use hazard).
- `Branch`  in  1  branch taken, resolved this cycle.
- `BranchTarget`  in  WIDTH  branch destination.
- `Jump`  in  1  unconditional jump this cycle.
- `JumpTarget`  in  WIDTH  jump destination.
- `NextAddress`  out  WIDTH  combinational; drives the PC register input.
- `IF_Flush`  out  1  registered; squash the instruction in IF/ID.
- `AddrFault`  out  1  sticky; a redirect target was out of window.
- `StallTimeout`  out  1  sticky; `Stall` exceeded `MAX_STALL`.
- `State`  out  2  current FSM state, for debug.

## Operation

**States** (encoding lives in the package):

- HOLD=0: `NextAddress`=0. All inputs are ignored.
- RUN=1: normal operation.
- STALL=2: the previous cycle was a stall.
- FLUSH=3: the previous cycle accepted a redirect.

**Reset**

- State goes to HOLD.
- `IF_Flush`, `AddrFault` and `StallTimeout` go to 0.
- The stall counter goes to 0.

**Transitions**

- HOLD → RUN unconditionally after one cycle.
- In RUN, STALL and FLUSH, the next state is chosen by priority, Jump > Branch > Stall > sequential:
  - Jump or Branch → FLUSH.
  - Stall → STALL.
  - otherwise → RUN.

**NextAddress**, in RUN, STALL and FLUSH:

- Jump: `JumpTarget`.
- else Branch: `BranchTarget`.
- else Stall: `PC`.
- else: `PC`+4.
- Rules applied to the selected value:
  - Low two bits are forced to 0.
  - A value above `PROG_LAST` becomes 0.
  - PC+4 is computed modulo 2^WIDTH; any carry-out is discarded and then wrapped to 0.

**Flags and counter**

- `AddrFault` sets when an accepted Jump or Branch target exceeds `PROG_LAST`. It clears only on Reset.
- A redirect overrides a simultaneous Stall: the target is taken and no hold occurs.
- Stall counter:
  - Increments in each cycle where Stall is accepted.
  - Saturates at `MAX_STALL`+1.
  - Clears on any non-stall cycle.
- `StallTimeout` sets when the counter reaches `MAX_STALL`+1. It is sticky until Reset.

## Timing

- `NextAddress` is combinational from the inputs and `State`, with zero latency. The PC register captures it on the same edge.
- `IF_Flush` is high for exactly the one cycle after a redirect is accepted, i.e. while State=FLUSH.
  - Back-to-back redirects keep it high continuously.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - The first fetch after release is from address 0.
  - The cycle after release is HOLD, then RUN. HOLD therefore lasts exactly one cycle after each Reset deassertion.
- Sticky flags update on the edge following the triggering cycle.

## Structure

- Package `pc_seq_pkg` contains:
  - the state enum `pc_state_t` (HOLD, RUN, STALL, FLUSH);
  - the instruction stride constant `INSTR_BYTES`=4;
  - the address-clamp function (word-align plus the `PROG_LAST` wrap).
- Natural sub-module: `stall_watchdog`, containing the saturating counter and `StallTimeout`.
- The FSM and next-address mux stay in `pc_sequencer`.

## Test plan

- **Reset then free-run:** pulse Reset for 2 cycles, then leave all inputs low.
  - Required: State=HOLD for one cycle with NextAddress=0.
  - Then PC takes 0,4,8,…,24,0.
  - Sequential wrap does not set AddrFault.
- **Branch with simultaneous Stall:** at PC=8, Branch=1, BranchTarget=20, Stall=1.
  - Required: NextAddress=20, next cycle State=FLUSH with IF_Flush=1.
  - The cycle after that, IF_Flush=0.
- **Jump over Branch:** Jump=1, JumpTarget=4, Branch=1, BranchTarget=16.
  - Required: NextAddress=4.
- **Out-of-window and misaligned target:**
  - BranchTarget=0x00000030 → NextAddress=0, and AddrFault=1 from the next cycle until Reset.
  - JumpTarget=0x00000007 → NextAddress=4.
- **Stall watchdog:** hold Stall for 16 cycles at PC=12.
  - Required: NextAddress=12 throughout, State=STALL.
  - StallTimeout=1 after the 16th stall cycle.
  - Holding Stall for 15 cycles instead leaves StallTimeout=0.
- **Asynchronous reset mid-redirect:** assert Reset between edges while State=FLUSH.
  - Required: IF_Flush=0 and State=HOLD immediately, without waiting for an edge.
  - Flags are cleared.
